multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32-subset datapath, including the custom lwi/ss/swap/lui/jump opcodes. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and the datapath shares one memory port between instruction fetch and data access. The block generates all per-state control strobes and handles variable-latency memory through a req/ready handshake with timeout. It also counts retired instructions and traps illegal opcodes into a sticky FAULT state.

Parameters:
MEM_TIMEOUT, 16, maximum wait cycles for mem_ready in FETCH/MEM before FAULT; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0]
take_branch  in  1  branch condition from the ALU, valid in EXEC
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write enable, qualified by mem_req
addr_sel  out  1  0 = PC, 1 = ALU result as memory address
ir_write  out  1  load IR from memory read data
pc_write  out  1  update PC
pc_src  out  1  0 = PC+4, 1 = branch/jump target
alu_src  out  1  ALU B input: 0 = rs2, 1 = immediate
alu_op  out  2  0 = add, 1 = sub/compare, 2 = funct-decoded, 3 = pass B
jump  out  1  unconditional jump, valid in EXEC
reg_address  out  1  ss addressing mode (rs2 field taken from inst[11:7])
reg_write  out  1  register-file write
reg_write2  out  1  second write port enable (swap)
mem_to_reg  out  1  writeback source is memory
fault  out  1  sticky illegal-opcode or timeout flag
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5
retired  out  CNT_W  retired-instruction count

Behaviour:
- Output style: strobes are combinational from state, latched op_q, mem_ready and take_branch. state, retired, fault and wait_cnt are registered.
- Reset: when rst=1 at a clock edge, state<=FETCH, retired<=0, fault<=0, wait_cnt<=0, op_q<=0. While rst=1, all strobes are forced to 0. Reset takes effect from any state, including mid-access; the aborted access is not retried.
- FETCH: mem_req=1, addr_sel=0.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
- DECODE: op_q<=opcode.
  - Opcode in {51, 99, 19, 3, 35, 7, 84, 55, 111, 39}: next state EXEC.
  - Any other opcode: next state FAULT.
- EXEC, decoded from op_q:
  - R-type (51): alu_op=2 -> WB.
  - I-type (19): alu_src=1, alu_op=2 -> WB.
  - lui (55): alu_src=1, alu_op=3 -> WB.
  - swap (84): alu_op=3 -> WB.
  - lw (3) / sw (35): alu_src=1, alu_op=0 -> MEM.
  - lwi (7): alu_op=0 -> MEM.
  - ss (39): alu_src=1, alu_op=2, reg_address=1 -> MEM.
  - Branch (99): alu_op=1, pc_write=take_branch, pc_src=1, retire, -> FETCH.
  - jump (111): jump=1, pc_write=1, pc_src=1, retire, -> FETCH.
- MEM: mem_req=1, addr_sel=1, with alu controls held as in EXEC.
  - mem_we=1 for sw/ss; reg_address=1 for ss.
  - On mem_ready: loads -> WB; stores retire -> FETCH.
- WB: reg_write=1.
  - mem_to_reg=1 for lw/lwi.
  - reg_write2=1 for swap.
  - Retire, -> FETCH.
- Latencies with zero-wait memory: ALU ops 4 cycles, loads 5, stores 4, branches/jumps 3.
- Each wait cycle in FETCH or MEM adds 1 cycle.
- Wait counter:
  - Cleared on entry to FETCH/MEM; increments each cycle in FETCH/MEM with mem_ready=0.
  - If wait_cnt == MEM_TIMEOUT-1 and mem_ready=0 (MEM_TIMEOUT>0): next state FAULT.
  - mem_ready in that same cycle wins over the timeout.
- FAULT: fault=1, all strobes 0, state holds until rst.
- retired: increments by 1 in each retiring cycle and wraps from all-ones to 0. It does not increment when entering FAULT.
- mem_ready outside FETCH/MEM is ignored.

Decomposition:
- Shared package ctrl_pkg:
  - state enum.
  - Opcode constants: OP_R=51, OP_BR=99, OP_I=19, OP_LW=3, OP_SW=35, OP_LWI=7, OP_SWAP=84, OP_LUI=55, OP_JAL=111, OP_SS=39.
  - alu_op encodings.
- One sub-module, ctrl_decode: combinational map from (state, op_q, mem_ready, take_branch) to the strobe bundle.
- The parent holds the state register, wait counter and retired counter.

Test Plan:
1. addi (op 19), mem_ready tied 1 -> state sequence 0,1,2,4,0; alu_src=1 and alu_op=2 in EXEC; reg_write=1 only in WB; retired 0->1.
2. lw (op 3), mem_ready low for 3 MEM cycles -> MEM held 4 cycles with mem_req=1, addr_sel=1; WB asserts mem_to_reg=1; 8 cycles total.
3. beq with take_branch=1, then again with take_branch=0 -> pc_write/pc_src=1 in EXEC versus pc_write=0; both return to FETCH after 3 cycles; retired +2.
4. swap (op 84) then ss (op 39) -> WB asserts reg_write=reg_write2=1; ss MEM asserts mem_we=1 and reg_address=1; no WB state for ss.
5. Opcode 0x7F in DECODE -> FAULT next cycle, fault=1, strobes 0 for 10 cycles; rst=1 -> state=0, fault=0, retired=0.
6. MEM_TIMEOUT=4 with mem_ready=0 in FETCH -> FAULT after exactly 4 FETCH cycles. Repeat with mem_ready=1 on the 4th cycle -> DECODE. Then assert rst mid-MEM -> FETCH with retired=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle sequencer: FSM states, opcodes, ALU op
// encodings and the control-strobe bundle driven into the datapath.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  localparam logic [6:0] OP_R    = 7'd51;
  localparam logic [6:0] OP_BR   = 7'd99;
  localparam logic [6:0] OP_I    = 7'd19;
  localparam logic [6:0] OP_LW   = 7'd3;
  localparam logic [6:0] OP_SW   = 7'd35;
  localparam logic [6:0] OP_LWI  = 7'd7;
  localparam logic [6:0] OP_SWAP = 7'd84;
  localparam logic [6:0] OP_LUI  = 7'd55;
  localparam logic [6:0] OP_JAL  = 7'd111;
  localparam logic [6:0] OP_SS   = 7'd39;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FN    = 2'd2;
  localparam logic [1:0] ALU_PASSB = 2'd3;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       jump;
    logic       reg_address;
    logic       reg_write;
    logic       reg_write2;
    logic       mem_to_reg;
  } strobes_t;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_address;
  } alu_ctrl_t;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_BR, OP_I, OP_LW, OP_SW, OP_LWI,
      OP_SWAP, OP_LUI, OP_JAL, OP_SS: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [6:0] op);
    return (op == OP_SW) || (op == OP_SS);
  endfunction

  function automatic logic op_is_load(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_LWI);
  endfunction

  // ALU setup shared by EXEC and MEM so the address stays stable during an access
  function automatic alu_ctrl_t alu_ctrl(input logic [6:0] op);
    alu_ctrl_t c;
    c = '0;
    case (op)
      OP_R:         c.alu_op = ALU_FN;
      OP_I:         begin c.alu_src = 1'b1; c.alu_op = ALU_FN;    end
      OP_LUI:       begin c.alu_src = 1'b1; c.alu_op = ALU_PASSB; end
      OP_SWAP:      c.alu_op = ALU_PASSB;
      OP_LW, OP_SW: begin c.alu_src = 1'b1; c.alu_op = ALU_ADD;   end
      OP_LWI:       c.alu_op = ALU_ADD;
      OP_SS:        begin c.alu_src = 1'b1; c.alu_op = ALU_FN; c.reg_address = 1'b1; end
      OP_BR:        c.alu_op = ALU_SUB;
      default:      c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: the controller drives strobes and status,
// the datapath returns opcode, branch condition and memory completion.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             take_branch;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             jump;
  logic             reg_address;
  logic             reg_write;
  logic             reg_write2;
  logic             mem_to_reg;
  logic             fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, take_branch, mem_ready,
    output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src,
           alu_op, jump, reg_address, reg_write, reg_write2, mem_to_reg,
           fault, state, retired
  );

  modport slave (
    output opcode, take_branch, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src,
           alu_op, jump, reg_address, reg_write, reg_write2, mem_to_reg,
           fault, state, retired
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational strobe generation from current state, latched opcode,
// memory completion and branch condition.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [6:0] op_i,
  input  logic       mem_ready_i,
  input  logic       take_branch_i,
  output strobes_t   strb_o
);

  alu_ctrl_t ac;
  assign ac = alu_ctrl(op_i);

  always_comb begin
    strb_o = '0;
    case (state_i)
      S_FETCH: begin
        strb_o.mem_req = 1'b1;
        if (mem_ready_i) begin
          strb_o.ir_write = 1'b1;
          strb_o.pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        strb_o.alu_src     = ac.alu_src;
        strb_o.alu_op      = ac.alu_op;
        strb_o.reg_address = ac.reg_address;
        if (op_i == OP_BR) begin
          strb_o.pc_write = take_branch_i;
          strb_o.pc_src   = 1'b1;
        end
        if (op_i == OP_JAL) begin
          strb_o.jump     = 1'b1;
          strb_o.pc_write = 1'b1;
          strb_o.pc_src   = 1'b1;
        end
      end
      S_MEM: begin
        strb_o.mem_req     = 1'b1;
        strb_o.addr_sel    = 1'b1;
        strb_o.alu_src     = ac.alu_src;
        strb_o.alu_op      = ac.alu_op;
        strb_o.reg_address = ac.reg_address;
        strb_o.mem_we      = op_is_store(op_i);
      end
      S_WB: begin
        strb_o.reg_write  = 1'b1;
        strb_o.mem_to_reg = op_is_load(op_i);
        strb_o.reg_write2 = (op_i == OP_SWAP);
      end
      default: strb_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout,
// retired-instruction counter and sticky fault state.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TO_M1  = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_e            state_q, state_d;
  logic [6:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              fault_q, fault_d;
  logic              retire;
  logic              timeout_hit;
  strobes_t          dec_strb, strb;

  assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt_q == WAIT_W'(TO_M1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      op_q       <= '0;
      wait_cnt_q <= '0;
      retired_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
      fault_q    <= fault_d;
    end
  end

  // The wait counter is zero everywhere except while stalled in FETCH/MEM,
  // so it is already clear on every entry to those states.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_cnt_d = '0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (timeout_hit) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        op_d    = bus.opcode;
        state_d = op_legal(bus.opcode) ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        if (op_q == OP_BR || op_q == OP_JAL) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (op_is_load(op_q) || op_is_store(op_q)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (op_is_store(op_q)) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (timeout_hit) state_d = S_FAULT;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    fault_d   = fault_q | (state_d == S_FAULT);
  end

  ctrl_decode u_decode (
    .state_i       (state_q),
    .op_i          (op_q),
    .mem_ready_i   (bus.mem_ready),
    .take_branch_i (bus.take_branch),
    .strb_o        (dec_strb)
  );

  assign strb = rst ? '0 : dec_strb;

  assign bus.mem_req     = strb.mem_req;
  assign bus.mem_we      = strb.mem_we;
  assign bus.addr_sel    = strb.addr_sel;
  assign bus.ir_write    = strb.ir_write;
  assign bus.pc_write    = strb.pc_write;
  assign bus.pc_src      = strb.pc_src;
  assign bus.alu_src     = strb.alu_src;
  assign bus.alu_op      = strb.alu_op;
  assign bus.jump        = strb.jump;
  assign bus.reg_address = strb.reg_address;
  assign bus.reg_write   = strb.reg_write;
  assign bus.reg_write2  = strb.reg_write2;
  assign bus.mem_to_reg  = strb.mem_to_reg;
  assign bus.fault       = fault_q;
  assign bus.state       = state_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: each stimulus cycle queues its expected state/strobes/fault/retired,
// and an independent monitor compares them against the DUT on the falling edge.
module tb_multicycle_ctrl;

  localparam logic [13:0] MRQ = 14'h2000;
  localparam logic [13:0] MWE = 14'h1000;
  localparam logic [13:0] ASL = 14'h0800;
  localparam logic [13:0] IRW = 14'h0400;
  localparam logic [13:0] PCW = 14'h0200;
  localparam logic [13:0] PCS = 14'h0100;
  localparam logic [13:0] ASR = 14'h0080;
  localparam logic [13:0] ASB = 14'h0020;
  localparam logic [13:0] AFN = 14'h0040;
  localparam logic [13:0] APB = 14'h0060;
  localparam logic [13:0] JMP = 14'h0010;
  localparam logic [13:0] RAD = 14'h0008;
  localparam logic [13:0] RW  = 14'h0004;
  localparam logic [13:0] RW2 = 14'h0002;
  localparam logic [13:0] M2R = 14'h0001;
  localparam logic [13:0] FI  = MRQ | IRW | PCW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(3)) bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef logic [20:0] exp_t;
  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  wire [20:0] act = {bus.state, bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write,
                     bus.pc_write, bus.pc_src, bus.alu_src, bus.alu_op, bus.jump,
                     bus.reg_address, bus.reg_write, bus.reg_write2, bus.mem_to_reg,
                     bus.fault, bus.retired};

  task automatic cyc(input logic [6:0] opc, input logic rdy, input logic br,
                     input logic [2:0] st, input logic [13:0] stb,
                     input logic flt, input logic [2:0] ret);
    bus.opcode      = opc;
    bus.mem_ready   = rdy;
    bus.take_branch = br;
    q.push_back({st, stb, flt, ret});
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n_chk++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL chk%0d state/strobes/fault/retired got %0d/%h/%0b/%0d want %0d/%h/%0b/%0d",
                   n_chk, act[20:18], act[17:4], act[3], act[2:0],
                   e[20:18], e[17:4], e[3], e[2:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.opcode = '0;
    bus.mem_ready = 1'b0;
    bus.take_branch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(7'd0, 1, 0, 3'd0, 14'h0, 0, 3'd0);
    rst = 1'b0;

    // addi
    cyc(7'd19, 1, 0, 3'd0, FI, 0, 3'd0);
    cyc(7'd19, 1, 0, 3'd1, 14'h0, 0, 3'd0);
    cyc(7'd19, 1, 0, 3'd2, ASR | AFN, 0, 3'd0);
    cyc(7'd19, 1, 0, 3'd4, RW, 0, 3'd0);
    // lw with three MEM wait cycles
    cyc(7'd3, 1, 0, 3'd0, FI, 0, 3'd1);
    cyc(7'd3, 1, 0, 3'd1, 14'h0, 0, 3'd1);
    cyc(7'd3, 1, 0, 3'd2, ASR, 0, 3'd1);
    for (int i = 0; i < 3; i++) cyc(7'd3, 0, 0, 3'd3, MRQ | ASL | ASR, 0, 3'd1);
    cyc(7'd3, 1, 0, 3'd3, MRQ | ASL | ASR, 0, 3'd1);
    cyc(7'd3, 1, 0, 3'd4, RW | M2R, 0, 3'd1);
    // beq taken, then not taken
    cyc(7'd99, 1, 1, 3'd0, FI, 0, 3'd2);
    cyc(7'd99, 1, 1, 3'd1, 14'h0, 0, 3'd2);
    cyc(7'd99, 1, 1, 3'd2, ASB | PCW | PCS, 0, 3'd2);
    cyc(7'd99, 1, 0, 3'd0, FI, 0, 3'd3);
    cyc(7'd99, 1, 0, 3'd1, 14'h0, 0, 3'd3);
    cyc(7'd99, 1, 0, 3'd2, ASB | PCS, 0, 3'd3);
    // swap, then ss
    cyc(7'd84, 1, 0, 3'd0, FI, 0, 3'd4);
    cyc(7'd84, 1, 0, 3'd1, 14'h0, 0, 3'd4);
    cyc(7'd84, 1, 0, 3'd2, APB, 0, 3'd4);
    cyc(7'd84, 1, 0, 3'd4, RW | RW2, 0, 3'd4);
    cyc(7'd39, 1, 0, 3'd0, FI, 0, 3'd5);
    cyc(7'd39, 1, 0, 3'd1, 14'h0, 0, 3'd5);
    cyc(7'd39, 1, 0, 3'd2, ASR | AFN | RAD, 0, 3'd5);
    cyc(7'd39, 1, 0, 3'd3, MRQ | MWE | ASL | ASR | AFN | RAD, 0, 3'd5);
    // illegal opcode -> sticky fault, cleared only by reset
    cyc(7'h7F, 1, 0, 3'd0, FI, 0, 3'd6);
    cyc(7'h7F, 1, 0, 3'd1, 14'h0, 0, 3'd6);
    for (int i = 0; i < 10; i++) cyc(7'h7F, 1, 1, 3'd5, 14'h0, 1, 3'd6);
    rst = 1'b1;
    cyc(7'h7F, 1, 1, 3'd5, 14'h0, 1, 3'd6);
    rst = 1'b0;
    // eight jumps: retired counts 0..7 and wraps to 0
    for (int i = 0; i < 8; i++) begin
      cyc(7'd111, 1, 0, 3'd0, FI, 0, 3'(i));
      cyc(7'd111, 1, 0, 3'd1, 14'h0, 0, 3'(i));
      cyc(7'd111, 1, 0, 3'd2, JMP | PCW | PCS, 0, 3'(i));
    end
    // fetch timeout after exactly four stalled cycles
    for (int i = 0; i < 4; i++) cyc(7'd19, 0, 0, 3'd0, MRQ, 0, 3'd0);
    cyc(7'd19, 1, 0, 3'd5, 14'h0, 1, 3'd0);
    rst = 1'b1;
    cyc(7'd19, 1, 0, 3'd5, 14'h0, 1, 3'd0);
    rst = 1'b0;
    cyc(7'd111, 1, 0, 3'd0, FI, 0, 3'd0);
    cyc(7'd111, 1, 0, 3'd1, 14'h0, 0, 3'd0);
    cyc(7'd111, 1, 0, 3'd2, JMP | PCW | PCS, 0, 3'd0);
    // mem_ready on the last allowed wait cycle beats the timeout
    for (int i = 0; i < 3; i++) cyc(7'd3, 0, 0, 3'd0, MRQ, 0, 3'd1);
    cyc(7'd3, 1, 0, 3'd0, FI, 0, 3'd1);
    cyc(7'd3, 1, 0, 3'd1, 14'h0, 0, 3'd1);
    cyc(7'd3, 1, 0, 3'd2, ASR, 0, 3'd1);
    cyc(7'd3, 0, 0, 3'd3, MRQ | ASL | ASR, 0, 3'd1);
    // reset in the middle of a MEM access
    rst = 1'b1;
    cyc(7'd3, 0, 0, 3'd3, 14'h0, 0, 3'd1);
    rst = 1'b0;
    cyc(7'd3, 0, 0, 3'd0, MRQ, 0, 3'd0);

    for (int i = 0; i < 4; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain pending expectations got %0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
